// File: rtl/dsp_seq_pkg.sv
// Shared FSM encoding, default widths and overflow helper for the sequential dot-product block.
package dsp_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  localparam int DEF_A_WIDTH   = 18;
  localparam int DEF_B_WIDTH   = 18;
  localparam int DEF_ACC_WIDTH = 48;
  localparam int DEF_LEN_WIDTH = 8;

  // Two's-complement add overflow: operands agree in sign, sum disagrees.
  function automatic logic add_overflow(input logic sign_x, input logic sign_y, input logic sign_sum);
    return (sign_x == sign_y) && (sign_sum != sign_x);
  endfunction

endpackage

// File: rtl/mac_datapath.sv
// Signed multiplier, optional product register and wrapping accumulator with sticky overflow.
module mac_datapath
  import dsp_seq_pkg::*;
#(
  parameter int A_WIDTH   = DEF_A_WIDTH,
  parameter int B_WIDTH   = DEF_B_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int MREG      = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_clear,
  input  logic                        i_en,
  input  logic signed [A_WIDTH-1:0]   i_a,
  input  logic signed [B_WIDTH-1:0]   i_b,
  output logic signed [ACC_WIDTH-1:0] o_acc,
  output logic                        o_ovf
);
  localparam int P_WIDTH = A_WIDTH + B_WIDTH;

  logic signed [P_WIDTH-1:0]   w_prod;
  logic signed [ACC_WIDTH-1:0] w_add_val;
  logic                        w_add_en;
  logic signed [ACC_WIDTH-1:0] w_sum;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic                        r_ovf;

  assign w_prod = P_WIDTH'(i_a) * P_WIDTH'(i_b);

  generate
    if (MREG != 0) begin : g_mreg
      logic signed [P_WIDTH-1:0] r_prod;
      logic                      r_pvalid;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_prod   <= '0;
          r_pvalid <= 1'b0;
        end else if (i_clear) begin
          r_prod   <= '0;
          r_pvalid <= 1'b0;
        end else begin
          r_pvalid <= i_en;
          if (i_en) r_prod <= w_prod;
        end
      end

      assign w_add_val = ACC_WIDTH'(r_prod);
      assign w_add_en  = r_pvalid;
    end else begin : g_nomreg
      assign w_add_val = ACC_WIDTH'(w_prod);
      assign w_add_en  = i_en;
    end
  endgenerate

  assign w_sum = r_acc + w_add_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (i_clear) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (w_add_en) begin
      r_acc <= w_sum;
      if (add_overflow(r_acc[ACC_WIDTH-1], w_add_val[ACC_WIDTH-1], w_sum[ACC_WIDTH-1]))
        r_ovf <= 1'b1;
    end
  end

  assign o_acc = r_acc;
  assign o_ovf = r_ovf;

endmodule

// File: rtl/dot_product_seq.sv
// Sequential signed dot product: counts len samples through the MAC, then holds the result.
module dot_product_seq
  import dsp_seq_pkg::*;
#(
  parameter int A_WIDTH   = DEF_A_WIDTH,
  parameter int B_WIDTH   = DEF_B_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int LEN_WIDTH = DEF_LEN_WIDTH,
  parameter int MREG      = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_start,
  input  logic [LEN_WIDTH-1:0]        i_len,
  output logic                        o_busy,
  input  logic                        i_in_valid,
  output logic                        o_in_ready,
  input  logic signed [A_WIDTH-1:0]   i_a,
  input  logic signed [B_WIDTH-1:0]   i_b,
  output logic                        o_out_valid,
  input  logic                        i_out_ready,
  output logic signed [ACC_WIDTH-1:0] o_result,
  output logic                        o_overflow
);
  state_t               r_state;
  state_t               w_next;
  logic [LEN_WIDTH-1:0] r_count;
  logic                 w_xfer;
  logic                 w_clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && i_start)
        r_count <= i_len;
      else if (w_xfer)
        r_count <= r_count - LEN_WIDTH'(1);
    end
  end

  always_comb begin
    w_next      = r_state;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    o_busy      = (r_state != S_IDLE);
    w_clear     = 1'b0;
    w_xfer      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_clear = 1'b1;
          w_next  = (i_len != '0) ? S_ACCUM : S_HOLD;
        end
      end
      S_ACCUM: begin
        o_in_ready = 1'b1;
        w_xfer     = i_in_valid;
        if (i_in_valid && r_count == LEN_WIDTH'(1))
          w_next = (MREG != 0) ? S_DRAIN : S_HOLD;
      end
      S_DRAIN: w_next = S_HOLD;
      S_HOLD: begin
        o_out_valid = 1'b1;
        if (i_out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  mac_datapath #(
    .A_WIDTH  (A_WIDTH),
    .B_WIDTH  (B_WIDTH),
    .ACC_WIDTH(ACC_WIDTH),
    .MREG     (MREG)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .i_clear(w_clear),
    .i_en   (w_xfer),
    .i_a    (i_a),
    .i_b    (i_b),
    .o_acc  (o_result),
    .o_ovf  (o_overflow)
  );

endmodule

// File: tb/tb_dot_product_seq.sv
// Directed bench for dot_product_seq: MREG=1, MREG=0 and a 36-bit accumulator instance.
module tb_dot_product_seq;

  logic clk;
  logic rst;
  logic              start_s  [3];
  logic [7:0]        len_s    [3];
  logic              in_vld   [3];
  logic              out_rdy  [3];
  logic signed [17:0] a_s     [3];
  logic signed [17:0] b_s     [3];
  logic              busy_o   [3];
  logic              in_rdy   [3];
  logic              out_vld  [3];
  logic              ovf_o    [3];
  logic signed [47:0] res0;
  logic signed [47:0] res1;
  logic signed [35:0] res2;

  int total = 0;
  int bad   = 0;
  int lat;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  dot_product_seq #(.MREG(1)) u_m1 (
    .clk(clk), .rst(rst), .i_start(start_s[0]), .i_len(len_s[0]), .o_busy(busy_o[0]),
    .i_in_valid(in_vld[0]), .o_in_ready(in_rdy[0]), .i_a(a_s[0]), .i_b(b_s[0]),
    .o_out_valid(out_vld[0]), .i_out_ready(out_rdy[0]), .o_result(res0), .o_overflow(ovf_o[0])
  );

  dot_product_seq #(.MREG(0)) u_m0 (
    .clk(clk), .rst(rst), .i_start(start_s[1]), .i_len(len_s[1]), .o_busy(busy_o[1]),
    .i_in_valid(in_vld[1]), .o_in_ready(in_rdy[1]), .i_a(a_s[1]), .i_b(b_s[1]),
    .o_out_valid(out_vld[1]), .i_out_ready(out_rdy[1]), .o_result(res1), .o_overflow(ovf_o[1])
  );

  dot_product_seq #(.ACC_WIDTH(36), .MREG(1)) u_w36 (
    .clk(clk), .rst(rst), .i_start(start_s[2]), .i_len(len_s[2]), .o_busy(busy_o[2]),
    .i_in_valid(in_vld[2]), .o_in_ready(in_rdy[2]), .i_a(a_s[2]), .i_b(b_s[2]),
    .o_out_valid(out_vld[2]), .i_out_ready(out_rdy[2]), .o_result(res2), .o_overflow(ovf_o[2])
  );

  function automatic longint res_of(input int idx);
    longint r;
    case (idx)
      0:       r = res0;
      1:       r = res1;
      default: r = res2;
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int idx, input logic [7:0] n);
    start_s[idx] = 1'b1;
    len_s[idx]   = n;
    tick();
    start_s[idx] = 1'b0;
  endtask

  task automatic send(input int idx, input logic signed [17:0] va, input logic signed [17:0] vb);
    bit ok;
    ok = 1'b0;
    in_vld[idx] = 1'b1;
    a_s[idx]    = va;
    b_s[idx]    = vb;
    for (int i = 0; i < 20; i++) begin
      if (in_rdy[idx]) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    in_vld[idx] = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_out(input int idx, output int l);
    l = 1;
    while (!out_vld[idx] && l < 20) begin
      tick();
      l++;
    end
  endtask

  task automatic release_out(input int idx);
    out_rdy[idx] = 1'b1;
    tick();
    out_rdy[idx] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0; len_s[i] = '0; in_vld[i] = 1'b0; out_rdy[i] = 1'b0;
      a_s[i] = '0; b_s[i] = '0;
    end
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("rst_busy", longint'(busy_o[i]), 0);
      chk("rst_in_ready", longint'(in_rdy[i]), 0);
      chk("rst_out_valid", longint'(out_vld[i]), 0);
      chk("rst_result", res_of(i), 0);
      chk("rst_overflow", longint'(ovf_o[i]), 0);
    end
    rst = 1'b0;

    // 1*5+2*6+3*7+4*8 = 70, MREG=1
    do_start(0, 8'd4);
    chk("t1_busy", longint'(busy_o[0]), 1);
    send(0, 18'sd1, 18'sd5);
    send(0, 18'sd2, 18'sd6);
    send(0, 18'sd3, 18'sd7);
    send(0, 18'sd4, 18'sd8);
    wait_out(0, lat);
    chk("t1_latency", lat, 2);
    chk("t1_result", res_of(0), 70);
    chk("t1_overflow", longint'(ovf_o[0]), 0);
    chk("t1_in_ready_hold", longint'(in_rdy[0]), 0);
    release_out(0);
    chk("t1_out_valid_low", longint'(out_vld[0]), 0);
    chk("t1_busy_low", longint'(busy_o[0]), 0);
    chk("t1_result_retained", res_of(0), 70);

    // -3*100 + -3*-1 + -3*2 = -303, MREG=0, 2-cycle gaps
    do_start(1, 8'd3);
    send(1, -18'sd3, 18'sd100);
    tick();
    tick();
    chk("t2_gap_result", res_of(1), -300);
    send(1, -18'sd3, -18'sd1);
    tick();
    tick();
    send(1, -18'sd3, 18'sd2);
    wait_out(1, lat);
    chk("t2_latency", lat, 1);
    chk("t2_result", res_of(1), -303);
    chk("t2_overflow", longint'(ovf_o[1]), 0);
    release_out(1);

    // len=0 completes immediately with zero result
    do_start(0, 8'd0);
    chk("t3_out_valid", longint'(out_vld[0]), 1);
    chk("t3_result", res_of(0), 0);
    chk("t3_in_ready", longint'(in_rdy[0]), 0);
    release_out(0);
    chk("t3_idle", longint'(busy_o[0]), 0);

    // 2 * 2^34 wraps a 36-bit accumulator to -2^35
    do_start(2, 8'd2);
    send(2, -18'sd131072, -18'sd131072);
    send(2, -18'sd131072, -18'sd131072);
    wait_out(2, lat);
    chk("t4_latency", lat, 2);
    chk("t4_result", res_of(2), -64'sd34359738368);
    chk("t4_overflow", longint'(ovf_o[2]), 1);
    release_out(2);
    chk("t4_overflow_sticky_idle", longint'(ovf_o[2]), 1);
    do_start(2, 8'd1);
    chk("t4_overflow_cleared", longint'(ovf_o[2]), 0);
    send(2, 18'sd1, 18'sd1);
    wait_out(2, lat);
    chk("t4_second_result", res_of(2), 1);
    release_out(2);

    // backpressure in HOLD with stray start pulses
    do_start(0, 8'd1);
    send(0, 18'sd3, -18'sd4);
    wait_out(0, lat);
    chk("t5_latency", lat, 2);
    for (int i = 0; i < 5; i++) begin
      start_s[0] = 1'b1;
      len_s[0]   = 8'd2;
      tick();
      chk("t5_hold_valid", longint'(out_vld[0]), 1);
      chk("t5_hold_result", res_of(0), -12);
    end
    start_s[0] = 1'b0;
    release_out(0);
    chk("t5_released", longint'(out_vld[0]), 0);
    chk("t5_not_restarted", longint'(busy_o[0]), 0);

    // out_ready already high when HOLD is entered
    out_rdy[1] = 1'b1;
    do_start(1, 8'd1);
    send(1, 18'sd2, 18'sd2);
    chk("t6_out_valid", longint'(out_vld[1]), 1);
    chk("t6_result", res_of(1), 4);
    tick();
    chk("t6_one_cycle", longint'(out_vld[1]), 0);
    out_rdy[1] = 1'b0;

    // reset mid-operation discards it
    do_start(0, 8'd4);
    send(0, 18'sd1, 18'sd1);
    send(0, 18'sd2, 18'sd2);
    rst = 1'b1;
    #1;
    chk("t7_busy", longint'(busy_o[0]), 0);
    chk("t7_in_ready", longint'(in_rdy[0]), 0);
    chk("t7_out_valid", longint'(out_vld[0]), 0);
    chk("t7_result", res_of(0), 0);
    chk("t7_overflow", longint'(ovf_o[0]), 0);
    tick();
    rst = 1'b0;
    do_start(0, 8'd1);
    chk("t7_restart_busy", longint'(busy_o[0]), 1);
    chk("t7_restart_in_ready", longint'(in_rdy[0]), 1);
    send(0, 18'sd7, 18'sd6);
    wait_out(0, lat);
    chk("t7_latency", lat, 2);
    chk("t7_result_final", res_of(0), 42);
    release_out(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dot_product_seq.md
DOT_PRODUCT_SEQ -- requirements
Module: dot_product_seq

Interface
REQ-001 Parameter A_WIDTH, default 18, signed width of operand a.
REQ-002 Parameter B_WIDTH, default 18, signed width of operand b.
REQ-003 Parameter ACC_WIDTH, default 48, signed accumulator/result width; SHALL be >= A_WIDTH+B_WIDTH.
REQ-004 Parameter LEN_WIDTH, default 8, width of vector-length field.
REQ-005 Parameter MREG, default 1, product pipeline register present (1) or bypassed (0).
REQ-006 Reset rst, asynchronous, active-high; clock clk.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rst  input  1  asynchronous active-high reset.
REQ-009 start  input  1  single-cycle request to begin a dot product.
REQ-010 len  input  LEN_WIDTH  unsigned sample count, sampled when start accepted.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 in_valid / in_ready  input / output  1 each  sample handshake; transfer when both high at a rising edge.
REQ-013 a / b  input  A_WIDTH / B_WIDTH  signed operands, valid with in_valid.
REQ-014 out_valid / out_ready  output / input  1 each  result handshake.
REQ-015 result  output  ACC_WIDTH  signed sum of a*b over the vector.
REQ-016 overflow  output  1  sticky: accumulator wrapped during current operation.

Function
REQ-017 FSM states IDLE, ACCUM, DRAIN, HOLD; encoding free.
REQ-018 IDLE: start=1, len!=0 -> latch len into remaining-count, clear accumulator and overflow, go ACCUM.
REQ-019 IDLE: start=1, len=0 -> result=0, overflow=0, go HOLD (out_valid next cycle).
REQ-020 start SHALL be ignored in every state other than IDLE.
REQ-021 in_ready SHALL be 1 only in ACCUM; 0 in all other states, combinationally from state.
REQ-022 ACCUM: each transfer decrements remaining-count; transfer with count=1 -> DRAIN if MREG=1, else HOLD.
REQ-023 MREG=1: a*b SHALL be registered on the transfer edge with a product-valid flag; accumulator adds the registered product on the following edge.
REQ-024 MREG=0: accumulator SHALL add a*b on the transfer edge itself.
REQ-025 DRAIN: lasts exactly one cycle (final product absorbed), then HOLD.
REQ-026 Latency: out_valid SHALL rise 1+MREG cycles after the edge of the last input transfer.
REQ-027 Gaps (in_valid=0) in ACCUM SHALL stall with no accumulator change and no count change.
REQ-028 Product SHALL be full-precision signed, sign-extended to ACC_WIDTH before the add.
REQ-029 Accumulator SHALL wrap modulo 2^ACC_WIDTH; overflow set when operands of the add share sign and sum sign differs; stays set until next accepted start.
REQ-030 HOLD: out_valid=1, result and overflow stable; out_valid&out_ready -> IDLE, out_valid low next cycle.
REQ-031 out_ready SHALL have no effect outside HOLD; out_ready already high on entry to HOLD completes in one cycle.
REQ-032 result SHALL retain its last value in IDLE until the next start.

Reset
REQ-033 rst SHALL immediately force state IDLE, result=0, accumulator=0, product register and product-valid=0, count=0, overflow=0, out_valid=0, busy=0, in_ready=0.
REQ-034 rst asserted mid-operation SHALL discard the operation; no out_valid is produced for it.
REQ-035 First start is honoured on the first rising edge after rst deasserts.

Structure
REQ-036 State encoding and shared widths SHALL live in package dsp_seq_pkg.
REQ-037 Multiplier, product register and accumulator SHALL be one sub-module, mac_datapath, with clear/enable controls from the FSM.

Verification
REQ-038 len=4, a={1,2,3,4}, b={5,6,7,8} back-to-back, MREG=1 -> result=70, overflow=0, out_valid 2 cycles after last transfer.
REQ-039 len=3, a={-3,-3,-3}, b={100,-1,2}, in_valid gaps of 2 cycles between samples, MREG=0 -> result=-303, out_valid 1 cycle after last transfer.
REQ-040 len=0 start -> result=0, out_valid next cycle, in_ready never high.
REQ-041 ACC_WIDTH=36, len=2, a=b=-131072 -> wrap to result=-2^35, overflow=1; next start clears overflow.
REQ-042 out_ready held 0 for 5 cycles in HOLD plus start pulses -> result stable, starts ignored; out_ready=1 -> IDLE next cycle.
REQ-043 rst asserted after 2 of 4 transfers -> all outputs 0 immediately; new start len=1, a=7, b=6 -> result=42.
